spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Parametrised next-generation SPI master for the board controller.
- Programmable word length, chip-select count, SCLK divider, CPOL/CPHA mode and bit order per transaction.
- One transaction at a time on a shared MOSI/MISO/SCLK bus; one active-low CS per slave.
- Host side uses a start/done/busy handshake on the BOARD_CLOCK domain.

Parameters:
DATA_W, 32, maximum bits per transaction; width of SPI_I/SPI_O.
NUM_CS, 3, number of chip-select outputs; must be >= 1.
CLK_DIV, 4, SCLK half-period in BOARD_CLOCK cycles; must be >= 1.
CS_GAP, 2, cycles from CS assert to first SCLK edge, and from last SCLK edge to CS deassert; must be >= 1.
SEL_W (local), clog2(NUM_CS), minimum 1.
LEN_W (local), clog2(DATA_W+1).

Ports:
BOARD_CLOCK  in  1  system clock; all logic on rising edge.
RST  in  1  asynchronous, active-high reset.
SPI_START_I  in  1  transaction request; sampled only in IDLE.
SPI_SEL_I  in  SEL_W  target slave index.
SPI_I  in  DATA_W  transmit word, right-justified.
SPI_LEN_I  in  LEN_W  bit count; 0 or >DATA_W clamps to DATA_W.
SPI_CPOL_I  in  1  SCLK idle level.
SPI_CPHA_I  in  1  0: sample on leading edge; 1: sample on trailing edge.
SPI_LSB_I  in  1  1: LSB first; 0: MSB first.
SPI_MISO  in  1  serial data from slave.
SPI_MOSI  out  1  serial data to slave.
SPI_CLK  out  1  SCLK.
SPI_CSS  out  NUM_CS  active-low chip selects.
SPI_O  out  DATA_W  received word, right-justified, upper bits zero.
SPI_DONE_O  out  1  one-cycle completion pulse.
SPI_ERR_O  out  1  one-cycle pulse with SPI_DONE_O on rejected SEL.
SPI_BUSY_O  out  1  high from acceptance until the cycle after DONE.

Behaviour:
- All outputs registered. Reset takes effect immediately, including mid-transaction:
  - SPI_CSS all ones; SPI_CLK 0; SPI_MOSI 0; SPI_O 0; DONE/ERR/BUSY 0.
  - State returns to IDLE; latched mode clears to CPOL=0.
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE: SPI_START_I=1 at edge T accepts the request.
  - Latches SEL, SPI_I, clamped LEN, CPOL, CPHA and LSB; sets BUSY at T+1.
  - If SEL >= NUM_CS: go to DONE; DONE and ERR pulse at T+1; no CS or SCLK activity; SPI_O unchanged.
- SETUP: CS[SEL] low from T+1 for CS_GAP cycles. SCLK held at CPOL.
  - MOSI presents the first bit: SPI_I[LEN-1] if MSB-first, SPI_I[0] if LSB-first.
- SHIFT: 2*LEN SCLK half-periods, each CLK_DIV cycles.
  - CPHA=0: sample MISO on leading edge; drive next MOSI bit on trailing edge; no MOSI change after the last edge.
  - CPHA=1: drive MOSI on leading edge (first bit also pre-driven in SETUP); sample on trailing edge.
  - SCLK returns to CPOL after the last edge.
  - Half-period and bit counters are sized from CLK_DIV and LEN_W; no wrap before LEN bits complete.
- HOLD: CS_GAP cycles with CS low and SCLK at CPOL.
- DONE: one cycle.
  - CS deasserts.
  - SPI_O loads the received bits: MSB-first shifts into bit 0, so the last bit received lands at bit 0; LSB-first places the first bit received at bit 0.
  - DONE pulses. BUSY drops the next cycle.
- Latency: DONE asserts at T + 1 + 2*CS_GAP + 2*LEN*CLK_DIV, registered.
  - With defaults and LEN=32: T+261.
- Back-to-back: at least one IDLE cycle with all CS high between transactions. START held high begins the next transaction at the first IDLE edge.
- START while BUSY is ignored; no queueing.
- Config inputs may change freely after acceptance.

Decomposition:
- Package spi_pkg: state encoding; CPOL/CPHA mode constants; clog2 function; LEN clamp function.
- One sub-module, spi_sclk_gen: divider counter enabled in SHIFT; emits lead_stb/trail_stb strobes and SCLK level from CPOL.
- Shift registers, counters and FSM stay in spi_master_param.

Test Plan:
- Mode 0, MSB-first, LEN=32, SEL=2, SPI_I=0xCCCCCCCE, MISO tied 1:
  - CSS=3'b011 throughout; 32 rising SCLK edges.
  - MOSI sequence matches 0xCCCCCCCE MSB-first.
  - SPI_O=0xFFFFFFFF; DONE exactly at T+261; ERR=0.
- Mode 3, LSB-first, LEN=8, SEL=0, MOSI looped to MISO, SPI_I=0x000000A5:
  - SCLK idles high before and after.
  - SPI_O=0x000000A5; CSS=3'b110 during transfer; DONE at T+69.
- Mode 1, MSB-first, LEN=12, loopback, SPI_I=0xFFFFFABC:
  - Exactly 12 SCLK pulses; SPI_O=0x00000ABC.
- SEL=3 with NUM_CS=3:
  - DONE and ERR pulse at T+1; CSS stays 3'b111; SCLK static.
- LEN=0, loopback, SPI_I=0x12345678:
  - Clamps to 32 bits; 32 pulses; SPI_O=0x12345678.
- START re-asserted mid-SHIFT: ignored; SPI_O unchanged by it.
  - Then RST pulse mid-SHIFT: CSS=3'b111, SCLK=0, BUSY=0 with no clock edge.
  - A new START after reset completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master: FSM states,
// SPI mode encoding, latched transaction config and width/length helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // Mode number is {CPOL, CPHA}.
  typedef enum logic [1:0] {
    SPI_MODE_0 = 2'b00,
    SPI_MODE_1 = 2'b01,
    SPI_MODE_2 = 2'b10,
    SPI_MODE_3 = 2'b11
  } spi_mode_e;

  typedef struct packed {
    spi_mode_e mode;
    logic      lsb;
  } spi_cfg_t;

  // Ceiling log2 with a floor of 1 so every derived vector has a legal width.
  function automatic int spi_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // A zero or oversized bit count means "full word".
  function automatic int spi_clamp_len(input int len, input int max_len);
    return (len == 0 || len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: while enabled, toggles SCLK every CLK_DIV cycles and flags the
// leading/trailing edge one cycle ahead so the master acts on the same edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cpol,
  output logic lead_stb,
  output logic trail_stb,
  output logic sclk
);

  localparam int DIV_W = spi_clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic             half_end;

  assign half_end  = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_stb  = half_end && !phase;
  assign trail_stb = half_end &&  phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      sclk    <= cpol;
    end else if (half_end) begin
      div_cnt <= '0;
      phase   <= !phase;
      sclk    <= !sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one transaction at a time with per-transaction
// length, CPOL/CPHA, bit order and slave select; start/done/busy host handshake.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int NUM_CS  = 3,
  parameter  int CLK_DIV = 4,
  parameter  int CS_GAP  = 2,
  localparam int SEL_W   = spi_clog2(NUM_CS),
  localparam int LEN_W   = spi_clog2(DATA_W + 1)
) (
  input  logic              BOARD_CLOCK,
  input  logic              RST,
  input  logic              SPI_START_I,
  input  logic [SEL_W-1:0]  SPI_SEL_I,
  input  logic [DATA_W-1:0] SPI_I,
  input  logic [LEN_W-1:0]  SPI_LEN_I,
  input  logic              SPI_CPOL_I,
  input  logic              SPI_CPHA_I,
  input  logic              SPI_LSB_I,
  input  logic              SPI_MISO,
  output logic              SPI_MOSI,
  output logic              SPI_CLK,
  output logic [NUM_CS-1:0] SPI_CSS,
  output logic [DATA_W-1:0] SPI_O,
  output logic              SPI_DONE_O,
  output logic              SPI_ERR_O,
  output logic              SPI_BUSY_O
);

  localparam int               IDX_W    = spi_clog2(DATA_W);
  localparam int               GAP_W    = spi_clog2(CS_GAP);
  localparam logic [SEL_W:0]   NUM_CS_V = (SEL_W + 1)'(NUM_CS);

  spi_state_e        state_q, state_d;
  spi_cfg_t          cfg_q;
  logic [1:0]        mode_bits;
  logic              cpol_q, cpha_q;
  logic [SEL_W-1:0]  sel_q, css_sel;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [LEN_W-1:0]  len_q, len_c, bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              accept, sel_ok, gap_last, last_bit, active_d;
  logic              cpol_idle, lead_stb, trail_stb;

  // Wire position of bit k on the serial line, given order and length.
  function automatic logic [IDX_W-1:0] bit_pos(input logic lsb,
                                               input logic [LEN_W-1:0] len,
                                               input logic [LEN_W-1:0] k);
    logic [LEN_W-1:0] p;
    p = lsb ? k : len - k - LEN_W'(1);
    return p[IDX_W-1:0];
  endfunction

  assign mode_bits = cfg_q.mode;
  assign cpol_q    = mode_bits[1];
  assign cpha_q    = mode_bits[0];
  assign accept    = (state_q == ST_IDLE) && SPI_START_I;
  assign sel_ok    = {1'b0, SPI_SEL_I} < NUM_CS_V;
  assign len_c     = LEN_W'(spi_clamp_len(int'(SPI_LEN_I), DATA_W));
  assign gap_last  = gap_cnt == GAP_W'(CS_GAP - 1);
  assign last_bit  = bit_cnt == len_q - LEN_W'(1);
  // SCLK must sit at the new CPOL from the first SETUP cycle.
  assign cpol_idle = (accept && sel_ok) ? SPI_CPOL_I : cpol_q;
  assign css_sel   = accept ? SPI_SEL_I : sel_q;
  assign active_d  = state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD};

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (BOARD_CLOCK),
    .rst       (RST),
    .en        (state_q == ST_SHIFT),
    .cpol      (cpol_idle),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .sclk      (SPI_CLK)
  );

  always_ff @(posedge BOARD_CLOCK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (SPI_START_I) state_d = sel_ok ? ST_SETUP : ST_DONE;
      ST_SETUP: if (gap_last) state_d = ST_SHIFT;
      ST_SHIFT: if (trail_stb && last_bit) state_d = ST_HOLD;
      ST_HOLD:  if (gap_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLOCK or posedge RST) begin
    if (RST) begin
      SPI_MOSI   <= 1'b0;
      SPI_CSS    <= '1;
      SPI_O      <= '0;
      SPI_DONE_O <= 1'b0;
      SPI_ERR_O  <= 1'b0;
      SPI_BUSY_O <= 1'b0;
      cfg_q      <= '0;
      sel_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      len_q      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      SPI_BUSY_O <= state_d != ST_IDLE;
      SPI_DONE_O <= state_d == ST_DONE;
      SPI_ERR_O  <= accept && !sel_ok;
      SPI_CSS    <= active_d ? ~(NUM_CS'(1) << css_sel) : '1;

      if (state_d != state_q)
        gap_cnt <= '0;
      else if (state_q == ST_SETUP || state_q == ST_HOLD)
        gap_cnt <= gap_cnt + GAP_W'(1);

      if (accept && sel_ok) begin
        sel_q    <= SPI_SEL_I;
        tx_q     <= SPI_I;
        len_q    <= len_c;
        cfg_q    <= '{mode: spi_mode_e'({SPI_CPOL_I, SPI_CPHA_I}), lsb: SPI_LSB_I};
        rx_q     <= '0;
        bit_cnt  <= '0;
        SPI_MOSI <= SPI_I[bit_pos(SPI_LSB_I, len_c, '0)];
      end

      if (lead_stb) begin
        if (cpha_q) SPI_MOSI <= tx_q[bit_pos(cfg_q.lsb, len_q, bit_cnt)];
        else        rx_q[bit_pos(cfg_q.lsb, len_q, bit_cnt)] <= SPI_MISO;
      end

      if (trail_stb) begin
        if (cpha_q)
          rx_q[bit_pos(cfg_q.lsb, len_q, bit_cnt)] <= SPI_MISO;
        else if (!last_bit)
          SPI_MOSI <= tx_q[bit_pos(cfg_q.lsb, len_q, bit_cnt + LEN_W'(1))];
        bit_cnt <= bit_cnt + LEN_W'(1);
      end

      if (state_q == ST_HOLD && state_d == ST_DONE)
        SPI_O <= rx_q;
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: modes, bit order, length clamp,
// bad select, START while busy, and asynchronous reset mid-transfer.
module tb_spi_master_param;

  localparam int DATA_W  = 32;
  localparam int NUM_CS  = 3;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int SEL_W   = 2;
  localparam int LEN_W   = 6;

  logic              BOARD_CLOCK, RST, SPI_START_I;
  logic [SEL_W-1:0]  SPI_SEL_I;
  logic [DATA_W-1:0] SPI_I;
  logic [LEN_W-1:0]  SPI_LEN_I;
  logic              SPI_CPOL_I, SPI_CPHA_I, SPI_LSB_I, SPI_MISO;
  logic              SPI_MOSI, SPI_CLK, SPI_DONE_O, SPI_ERR_O, SPI_BUSY_O;
  logic [NUM_CS-1:0] SPI_CSS;
  logic [DATA_W-1:0] SPI_O;

  logic loop_en, miso_tie;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          r_lat, r_changes, r_css_bad;
  logic [31:0] r_mosi;
  logic        r_sclk_first, r_sclk_last, r_err, r_busy_first, r_busy_after, r_timeout;
  logic [2:0]  r_css_first, r_css_after;

  spi_master_param #(
    .DATA_W(DATA_W), .NUM_CS(NUM_CS), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
  ) dut (
    .BOARD_CLOCK (BOARD_CLOCK),
    .RST         (RST),
    .SPI_START_I (SPI_START_I),
    .SPI_SEL_I   (SPI_SEL_I),
    .SPI_I       (SPI_I),
    .SPI_LEN_I   (SPI_LEN_I),
    .SPI_CPOL_I  (SPI_CPOL_I),
    .SPI_CPHA_I  (SPI_CPHA_I),
    .SPI_LSB_I   (SPI_LSB_I),
    .SPI_MISO    (SPI_MISO),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_CLK     (SPI_CLK),
    .SPI_CSS     (SPI_CSS),
    .SPI_O       (SPI_O),
    .SPI_DONE_O  (SPI_DONE_O),
    .SPI_ERR_O   (SPI_ERR_O),
    .SPI_BUSY_O  (SPI_BUSY_O)
  );

  initial BOARD_CLOCK = 1'b0;
  always #5 BOARD_CLOCK = ~BOARD_CLOCK;

  assign SPI_MISO = loop_en ? SPI_MOSI : miso_tie;

  // Request presented at a falling edge, accepted at the next rising edge T.
  task automatic issue(input logic [1:0] sel, input logic [31:0] data,
                       input logic [5:0] len, input logic cpol, input logic cpha,
                       input logic lsb);
    @(negedge BOARD_CLOCK);
    SPI_SEL_I   = sel;
    SPI_I       = data;
    SPI_LEN_I   = len;
    SPI_CPOL_I  = cpol;
    SPI_CPHA_I  = cpha;
    SPI_LSB_I   = lsb;
    SPI_START_I = 1'b1;
    @(posedge BOARD_CLOCK);
    #1 SPI_START_I = 1'b0;
  endtask

  // Runs one transaction; r_lat is the cycle index (T+r_lat) where DONE is seen.
  task automatic run_xfer(input logic [1:0] sel, input logic [31:0] data,
                          input logic [5:0] len, input logic cpol, input logic cpha,
                          input logic lsb, input logic [2:0] exp_css, input int poke_at);
    logic prev;
    issue(sel, data, len, cpol, cpha, lsb);
    r_lat = 0; r_changes = 0; r_css_bad = 0; r_mosi = '0; r_timeout = 1'b1;
    prev = 1'b0; r_err = 1'b0; r_sclk_last = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge BOARD_CLOCK);
      r_lat = k;
      if (k == poke_at) begin SPI_I = '0; SPI_START_I = 1'b1; end
      if (k == poke_at + 3) SPI_START_I = 1'b0;
      if (k == 1) begin
        r_sclk_first = SPI_CLK; r_busy_first = SPI_BUSY_O; r_css_first = SPI_CSS;
      end else if (SPI_CLK !== prev) begin
        r_changes++;
        if (SPI_CLK === (cpol ^ !cpha)) r_mosi = {r_mosi[30:0], SPI_MOSI};
      end
      prev = SPI_CLK;
      if (SPI_DONE_O === 1'b1) begin
        r_sclk_last = SPI_CLK; r_err = SPI_ERR_O; r_timeout = 1'b0;
        break;
      end
      if (SPI_CSS !== exp_css) r_css_bad++;
    end
    @(negedge BOARD_CLOCK);
    r_busy_after = SPI_BUSY_O;
    r_css_after  = SPI_CSS;
    n_tests++;
    if (r_timeout) begin n_fail++; $display("FAIL done_timeout: no DONE within 2000 cycles"); end
  endtask

  task automatic test_reset();
    @(negedge BOARD_CLOCK);
    RST = 1'b0;
    @(negedge BOARD_CLOCK);
    n_tests++;
    if (SPI_CSS !== 3'b111 || SPI_CLK !== 1'b0 || SPI_MOSI !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus: css=%b clk=%b mosi=%b want 111/0/0", SPI_CSS, SPI_CLK, SPI_MOSI);
    end
    n_tests++;
    if (SPI_O !== 32'h0 || {SPI_DONE_O, SPI_ERR_O, SPI_BUSY_O} !== 3'b000) begin
      n_fail++; $display("FAIL reset_host: o=%h done/err/busy=%b want 0/000", SPI_O, {SPI_DONE_O, SPI_ERR_O, SPI_BUSY_O});
    end
  endtask

  task automatic test_mode0_msb32();
    loop_en = 1'b0; miso_tie = 1'b1;
    run_xfer(2'd2, 32'hCCCCCCCE, 6'd32, 1'b0, 1'b0, 1'b0, 3'b011, -10);
    n_tests++; if (r_lat !== 261) begin n_fail++; $display("FAIL m0_latency: got %0d want 261", r_lat); end
    n_tests++; if (SPI_O !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL m0_rx: got %h want ffffffff", SPI_O); end
    n_tests++; if (r_mosi !== 32'hCCCCCCCE) begin n_fail++; $display("FAIL m0_mosi: got %h want ccccccce", r_mosi); end
    n_tests++; if (r_changes !== 64) begin n_fail++; $display("FAIL m0_sclk_edges: got %0d want 64", r_changes); end
    n_tests++; if (r_css_bad !== 0) begin n_fail++; $display("FAIL m0_css: %0d cycles not 011", r_css_bad); end
    n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL m0_err: got %b want 0", r_err); end
    n_tests++; if (r_busy_first !== 1'b1 || r_busy_after !== 1'b0 || r_css_after !== 3'b111) begin
      n_fail++; $display("FAIL m0_busy: first=%b after=%b css_after=%b want 1/0/111", r_busy_first, r_busy_after, r_css_after);
    end
  endtask

  task automatic test_mode3_lsb8();
    loop_en = 1'b1;
    run_xfer(2'd0, 32'h000000A5, 6'd8, 1'b1, 1'b1, 1'b1, 3'b110, -10);
    n_tests++; if (r_lat !== 69) begin n_fail++; $display("FAIL m3_latency: got %0d want 69", r_lat); end
    n_tests++; if (SPI_O !== 32'h000000A5) begin n_fail++; $display("FAIL m3_rx: got %h want 000000a5", SPI_O); end
    n_tests++; if (r_sclk_first !== 1'b1 || r_sclk_last !== 1'b1) begin
      n_fail++; $display("FAIL m3_sclk_idle: before=%b after=%b want 1/1", r_sclk_first, r_sclk_last);
    end
    n_tests++; if (r_css_bad !== 0 || r_changes !== 16) begin
      n_fail++; $display("FAIL m3_bus: css_bad=%0d edges=%0d want 0/16", r_css_bad, r_changes);
    end
    n_tests++; if (r_mosi[7:0] !== 8'hA5) begin n_fail++; $display("FAIL m3_mosi: got %h want a5", r_mosi[7:0]); end
  endtask

  task automatic test_mode1_msb12();
    loop_en = 1'b1;
    run_xfer(2'd1, 32'hFFFFFABC, 6'd12, 1'b0, 1'b1, 1'b0, 3'b101, -10);
    n_tests++; if (r_changes !== 24) begin n_fail++; $display("FAIL m1_pulses: edges=%0d want 24", r_changes); end
    n_tests++; if (SPI_O !== 32'h00000ABC) begin n_fail++; $display("FAIL m1_rx: got %h want 00000abc", SPI_O); end
    n_tests++; if (r_lat !== 101) begin n_fail++; $display("FAIL m1_latency: got %0d want 101", r_lat); end
    n_tests++; if (r_mosi[11:0] !== 12'hABC) begin n_fail++; $display("FAIL m1_mosi: got %h want abc", r_mosi[11:0]); end
  endtask

  task automatic test_bad_sel();
    loop_en = 1'b1;
    run_xfer(2'd3, 32'h55AA55AA, 6'd8, 1'b0, 1'b0, 1'b0, 3'b111, -10);
    n_tests++; if (r_lat !== 1 || r_err !== 1'b1) begin
      n_fail++; $display("FAIL badsel_done: lat=%0d err=%b want 1/1", r_lat, r_err);
    end
    n_tests++; if (r_css_first !== 3'b111 || r_changes !== 0 || r_sclk_first !== 1'b0) begin
      n_fail++; $display("FAIL badsel_bus: css=%b edges=%0d sclk=%b want 111/0/0", r_css_first, r_changes, r_sclk_first);
    end
    n_tests++; if (SPI_O !== 32'h00000ABC) begin n_fail++; $display("FAIL badsel_rx: got %h want 00000abc", SPI_O); end
    n_tests++; if (r_busy_first !== 1'b1 || r_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL badsel_busy: first=%b after=%b want 1/0", r_busy_first, r_busy_after);
    end
  endtask

  task automatic test_len_clamp();
    loop_en = 1'b1;
    run_xfer(2'd0, 32'h12345678, 6'd0, 1'b0, 1'b0, 1'b0, 3'b110, -10);
    n_tests++; if (r_changes !== 64) begin n_fail++; $display("FAIL clamp_pulses: edges=%0d want 64", r_changes); end
    n_tests++; if (SPI_O !== 32'h12345678) begin n_fail++; $display("FAIL clamp_rx: got %h want 12345678", SPI_O); end
    n_tests++; if (r_lat !== 261) begin n_fail++; $display("FAIL clamp_latency: got %0d want 261", r_lat); end
  endtask

  task automatic test_start_while_busy();
    loop_en = 1'b1;
    run_xfer(2'd1, 32'hFFFF0000, 6'd32, 1'b0, 1'b0, 1'b0, 3'b101, 50);
    n_tests++; if (SPI_O !== 32'hFFFF0000) begin n_fail++; $display("FAIL busy_start_rx: got %h want ffff0000", SPI_O); end
    n_tests++; if (r_lat !== 261 || r_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_timing: lat=%0d busy_after=%b want 261/0", r_lat, r_busy_after);
    end
  endtask

  task automatic test_reset_mid_shift();
    loop_en = 1'b1;
    issue(2'd0, 32'h000000AA, 6'd8, 1'b1, 1'b1, 1'b0);
    repeat (12) @(negedge BOARD_CLOCK);
    n_tests++; if (SPI_CLK !== 1'b1 || SPI_CSS !== 3'b110 || SPI_BUSY_O !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: clk=%b css=%b busy=%b want 1/110/1", SPI_CLK, SPI_CSS, SPI_BUSY_O);
    end
    #2 RST = 1'b1;
    #1;
    n_tests++; if (SPI_CSS !== 3'b111 || SPI_CLK !== 1'b0 || SPI_BUSY_O !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: css=%b clk=%b busy=%b want 111/0/0", SPI_CSS, SPI_CLK, SPI_BUSY_O);
    end
    n_tests++; if (SPI_O !== 32'h0 || SPI_MOSI !== 1'b0) begin
      n_fail++; $display("FAIL rst_data: o=%h mosi=%b want 0/0", SPI_O, SPI_MOSI);
    end
    @(negedge BOARD_CLOCK);
    RST = 1'b0;
    run_xfer(2'd2, 32'h0000003C, 6'd8, 1'b0, 1'b0, 1'b0, 3'b011, -10);
    n_tests++; if (SPI_O !== 32'h0000003C || r_lat !== 69) begin
      n_fail++; $display("FAIL rst_recover: o=%h lat=%0d want 0000003c/69", SPI_O, r_lat);
    end
  endtask

  initial begin
    RST = 1'b1; SPI_START_I = 1'b0; SPI_SEL_I = '0; SPI_I = '0; SPI_LEN_I = '0;
    SPI_CPOL_I = 1'b0; SPI_CPHA_I = 1'b0; SPI_LSB_I = 1'b0;
    loop_en = 1'b0; miso_tie = 1'b0;
    repeat (3) @(negedge BOARD_CLOCK);
    test_reset();
    test_mode0_msb32();
    test_mode3_lsb8();
    test_mode1_msb12();
    test_bad_sel();
    test_len_clamp();
    test_start_while_busy();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
